// File: rtl/param_divider_pkg.sv
// Shared types for the iterative restoring divider.
// Holds the two-state control FSM encoding.
package param_divider_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/param_divider_step.sv
// One restoring divide iteration: trial-subtract divisor from the shifted partial remainder.
// Latency: combinational. Backpressure: none.
// A kept difference is always below the divisor, so WIDTH result bits suffice.
module param_divider_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_shift,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    always_comb begin
        q_bit    = (rem_shift >= {1'b0, divisor});
        // Low-bit subtraction is exact here because the true difference fits in WIDTH bits.
        rem_next = q_bit ? (rem_shift[WIDTH-1:0] - divisor) : rem_shift[WIDTH-1:0];
    end

endmodule

// File: rtl/param_divider.sv
// Iterative unsigned divider, one quotient bit per clock behind a start/done handshake.
// Latency: WIDTH cycles from accepted start to done. Backpressure: start ignored while busy.
module param_divider
    import param_divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_nxt;
    logic             q_bit;
    logic             accept;
    logic             last;

    assign accept    = (state == IDLE) && start;
    assign last      = (state == RUN) && (cnt == CW'(1));
    assign busy      = (state == RUN);
    assign rem_shift = {rem_q, dvd_q[WIDTH-1]};

    param_divider_step #(.WIDTH(WIDTH)) u_step (
        .rem_shift (rem_shift),
        .divisor   (dvs_q),
        .rem_next  (rem_nxt),
        .q_bit     (q_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == CW'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The dividend register doubles as the quotient shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                dvd_q <= dividend;
                dvs_q <= divisor;
                rem_q <= '0;
                cnt   <= CW'(WIDTH);
            end else if (state == RUN) begin
                rem_q <= rem_nxt;
                dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
                cnt   <= cnt - CW'(1);
                if (last) begin
                    quotient    <= (dvs_q == '0) ? '1 : {dvd_q[WIDTH-2:0], q_bit};
                    remainder   <= rem_nxt;
                    div_by_zero <= (dvs_q == '0);
                    done        <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_param_divider.sv
// Directed vector table plus hand-written corner sequences for param_divider.
// WIDTH=8 instance for directed cases, WIDTH=4 instance for an exhaustive identity sweep.
module tb_param_divider;

    logic       clk;
    logic       reset;

    logic       start8;
    logic [7:0] dividend8, divisor8, quot8, rem8;
    logic       busy8, done8, dz8;

    logic       start4;
    logic [3:0] dividend4, divisor4, quot4, rem4;
    logic       busy4, done4, dz4;

    int checks = 0;
    int errors = 0;

    param_divider #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .reset       (reset),
        .start       (start8),
        .dividend    (dividend8),
        .divisor     (divisor8),
        .busy        (busy8),
        .done        (done8),
        .quotient    (quot8),
        .remainder   (rem8),
        .div_by_zero (dz8)
    );

    param_divider #(.WIDTH(4)) dut4 (
        .clk         (clk),
        .reset       (reset),
        .start       (start4),
        .dividend    (dividend4),
        .divisor     (divisor4),
        .busy        (busy4),
        .done        (done4),
        .quotient    (quot4),
        .remainder   (rem4),
        .div_by_zero (dz4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Call at #1 after a rising edge with the DUT idle.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat,
                        output logic [7:0] q, output logic [7:0] r, output logic dz);
        dividend8 = a;
        divisor8  = b;
        start8    = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        q  = quot8;
        r  = rem8;
        dz = dz8;
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, output int lat,
                        output logic [3:0] q, output logic [3:0] r);
        dividend4 = a;
        divisor4  = b;
        start4    = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat = 0;
        while (!done4 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        q = quot4;
        r = rem4;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       vecs[12];
        int         lat;
        logic [7:0] q, r;
        logic       dz;
        logic [3:0] q4, r4;

        vecs[0]  = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0};
        vecs[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0};
        vecs[2]  = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0};
        vecs[3]  = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0};
        vecs[4]  = '{8'd37,  8'd0,   8'd255, 8'd37, 1'b1};
        vecs[5]  = '{8'd0,   8'd5,   8'd0,   8'd0,  1'b0};
        vecs[6]  = '{8'd200, 8'd3,   8'd66,  8'd2,  1'b0};
        vecs[7]  = '{8'd128, 8'd16,  8'd8,   8'd0,  1'b0};
        vecs[8]  = '{8'd254, 8'd127, 8'd2,   8'd0,  1'b0};
        vecs[9]  = '{8'd1,   8'd255, 8'd0,   8'd1,  1'b0};
        vecs[10] = '{8'd0,   8'd0,   8'd255, 8'd0,  1'b1};
        vecs[11] = '{8'd171, 8'd10,  8'd17,  8'd1,  1'b0};

        reset = 1'b0;
        start8 = 1'b0; dividend8 = '0; divisor8 = '0;
        start4 = 1'b0; dividend4 = '0; divisor4 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", {31'd0, busy8}, 32'd0);
        chk("reset done", {31'd0, done8}, 32'd0);
        chk("reset quotient", {24'd0, quot8}, 32'd0);
        chk("reset remainder", {24'd0, rem8}, 32'd0);
        chk("reset div_by_zero", {31'd0, dz8}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            run8(vecs[i].dvd, vecs[i].dvs, lat, q, r, dz);
            chk($sformatf("vec%0d latency", i), lat, 32'd8);
            chk($sformatf("vec%0d quotient", i), {24'd0, q}, {24'd0, vecs[i].q});
            chk($sformatf("vec%0d remainder", i), {24'd0, r}, {24'd0, vecs[i].r});
            chk($sformatf("vec%0d div_by_zero", i), {31'd0, dz}, {31'd0, vecs[i].dz});
            @(posedge clk); #1;
            chk($sformatf("vec%0d done pulse width", i), {31'd0, done8}, 32'd0);
        end

        // Start while busy is ignored; results hold during RUN.
        dividend8 = 8'd100; divisor8 = 8'd7; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 3) begin
                chk("busy mid-run", {31'd0, busy8}, 32'd1);
                chk("quotient held mid-run", {24'd0, quot8}, 32'd17);
                dividend8 = 8'd1; divisor8 = 8'd1; start8 = 1'b1;
            end
            if (lat == 4) begin
                start8 = 1'b0; dividend8 = 8'd9; divisor8 = 8'd9;
            end
        end
        chk("ignored-start latency", lat, 32'd8);
        chk("ignored-start quotient", {24'd0, quot8}, 32'd14);
        chk("ignored-start remainder", {24'd0, rem8}, 32'd2);
        chk("busy low in done cycle", {31'd0, busy8}, 32'd0);

        // Start during the done cycle is accepted.
        dividend8 = 8'd200; divisor8 = 8'd3; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("back-to-back busy", {31'd0, busy8}, 32'd1);
        chk("back-to-back done cleared", {31'd0, done8}, 32'd0);
        lat = 0;
        while (!done8 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("back-to-back latency", lat, 32'd8);
        chk("back-to-back quotient", {24'd0, quot8}, 32'd66);
        chk("back-to-back remainder", {24'd0, rem8}, 32'd2);
        @(posedge clk); #1;
        chk("quotient held after done", {24'd0, quot8}, 32'd66);

        // Reset in the middle of a divide.
        dividend8 = 8'd100; divisor8 = 8'd7; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort busy", {31'd0, busy8}, 32'd0);
        chk("abort done", {31'd0, done8}, 32'd0);
        chk("abort quotient", {24'd0, quot8}, 32'd0);
        chk("abort remainder", {24'd0, rem8}, 32'd0);
        chk("abort div_by_zero", {31'd0, dz8}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run8(8'd50, 8'd5, lat, q, r, dz);
        chk("post-reset latency", lat, 32'd8);
        chk("post-reset quotient", {24'd0, q}, 32'd10);
        chk("post-reset remainder", {24'd0, r}, 32'd0);

        // Exhaustive WIDTH=4 identity sweep.
        @(posedge clk); #1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                run4(4'(a), 4'(b), lat, q4, r4);
                chk($sformatf("w4 %0d/%0d latency", a, b), lat, 32'd4);
                chk($sformatf("w4 %0d/%0d q*d+r", a, b), 32'(q4) * 32'(b) + 32'(r4), 32'(a));
                chk($sformatf("w4 %0d/%0d r<d", a, b), {31'd0, (32'(r4) < 32'(b))}, 32'd1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
